calculator_pipe: RTL

Parameterised, handshaked decimal four-function calculator core. Accepts 5-bit key codes from the keypad scanner, keeps a signed binary accumulator and operand, executes `+ - * /` with a pending-operator chain, and returns a sign-magnitude BCD display value plus an error flag. Division and binary-to-BCD conversion are iterative, so a `ready` handshake replaces the single-cycle assumption. The 7-segment stage downstream consumes the BCD display outputs.

---
 rtl/calculator_pipe.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calculator_pipe.sv
// Handshaked decimal four-function calculator core: pending-operator chain,
// iterative restoring divider and double-dabble conversion to sign-magnitude BCD.
module calculator_pipe #(
    parameter int DIGITS = 5,
    parameter int W      = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          Key_input,
    input  logic                valid,
    output logic                ready,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                disp_neg,
    output logic                err,
    output logic                disp_valid
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(W);
    localparam logic [2*W-1:0] LIM2 = (2*W)'(10**DIGITS - 1);
    localparam logic [W-1:0]   LIMW = W'(10**DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DIV, CONV, DONE} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t              state_q, state_d;
    op_t                 pop_q, pop_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic [W-1:0]        ent_q, ent_d;
    logic                ent_neg_q, ent_neg_d, ent_act_q, ent_act_d, err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [W-1:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, bin_q, bin_d;
    logic                qneg_q, qneg_d, cneg_q, cneg_d;
    logic [BW-1:0]       bcd_q, bcd_d, disp_bcd_q, disp_bcd_d;
    logic                disp_neg_q, disp_neg_d, err_out_q, err_out_d;
    logic                disp_valid_q, disp_valid_d;

    logic                accept, is_digit, is_ac, is_tog, is_op, is_eq;
    logic [W-1:0]        digit;
    op_t                 key_op;

    always_comb begin
        accept   = valid && (state_q == IDLE);
        is_digit = Key_input <= 5'd9;
        is_ac    = Key_input == 5'd10;
        is_tog   = Key_input == 5'd12;
        is_eq    = Key_input == 5'd17;
        is_op    = (Key_input >= 5'd13) && (Key_input <= 5'd16);
        digit    = W'(Key_input[3:0]);
        case (Key_input)
            5'd13:   key_op = OP_DIV;
            5'd14:   key_op = OP_MUL;
            5'd15:   key_op = OP_SUB;
            5'd16:   key_op = OP_ADD;
            default: key_op = OP_NONE;
        endcase
    end

    logic signed [W-1:0]   ent_s;
    logic signed [2*W-1:0] acc_x, ent_x, res;
    logic [2*W-1:0]        res_abs;
    logic [W-1:0]          ent_nx, acc_abs;

    // Single-cycle + - * evaluated at 2W so range overflow is visible.
    always_comb begin
        ent_s = ent_neg_q ? -$signed(ent_q) : $signed(ent_q);
        acc_x = {{W{acc_q[W-1]}}, acc_q};
        ent_x = {{W{ent_s[W-1]}}, ent_s};
        case (pop_q)
            OP_ADD:  res = acc_x + ent_x;
            OP_SUB:  res = acc_x - ent_x;
            OP_MUL:  res = acc_x * ent_x;
            default: res = ent_x;
        endcase
        res_abs = res[2*W-1] ? -res : res;
        ent_nx  = ent_q * W'(10) + digit;
        acc_abs = acc_q[W-1] ? -acc_q : acc_q;
    end

    logic [W:0]          rem_sh, rem_sub;
    logic                take;
    logic [W-1:0]        quo_n, rem_n, bin_n;
    logic signed [W-1:0] quo_s;
    logic [BW-1:0]       adj, bcd_n;

    // One restoring-divide step and one double-dabble step per cycle.
    always_comb begin
        rem_sh  = {rem_q, quo_q[W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        take    = !rem_sub[W];
        rem_n   = take ? rem_sub[W-1:0] : rem_sh[W-1:0];
        quo_n   = {quo_q[W-2:0], take};
        quo_s   = (qneg_q && (quo_n != '0)) ? -$signed(quo_n) : $signed(quo_n);
        adj     = '0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        {bcd_n, bin_n} = {adj, bin_q} << 1;
    end

    logic                go_conv, go_err;
    logic signed [W-1:0] src;

    always_comb begin
        state_d      = state_q;
        pop_d        = pop_q;
        acc_d        = acc_q;
        ent_d        = ent_q;
        ent_neg_d    = ent_neg_q;
        ent_act_d    = ent_act_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        iter_d       = iter_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        bin_d        = bin_q;
        qneg_d       = qneg_q;
        cneg_d       = cneg_q;
        bcd_d        = bcd_q;
        disp_bcd_d   = disp_bcd_q;
        disp_neg_d   = disp_neg_q;
        err_out_d    = err_out_q;
        disp_valid_d = 1'b0;
        go_conv      = 1'b0;
        go_err       = 1'b0;
        src          = '0;
        case (state_q)
            IDLE: if (accept) begin
                if (is_ac) begin
                    acc_d     = '0;
                    ent_d     = '0;
                    ent_neg_d = 1'b0;
                    ent_act_d = 1'b0;
                    cnt_d     = '0;
                    pop_d     = OP_NONE;
                    err_d     = 1'b0;
                    go_conv   = 1'b1;
                end else if (err_q) begin
                    // Keys are swallowed until AC.
                end else if (is_digit) begin
                    if (!ent_act_q) begin
                        ent_d     = digit;
                        ent_neg_d = 1'b0;
                        cnt_d     = (digit != '0) ? CW'(1) : '0;
                        ent_act_d = 1'b1;
                        src       = $signed(digit);
                        go_conv   = 1'b1;
                    end else if ((ent_q == '0) && (digit == '0)) begin
                        src     = ent_s;
                        go_conv = 1'b1;
                    end else if (cnt_q == CW'(DIGITS)) begin
                        go_err = 1'b1;
                    end else begin
                        ent_d   = ent_nx;
                        cnt_d   = cnt_q + CW'(1);
                        src     = ent_neg_q ? -$signed(ent_nx) : $signed(ent_nx);
                        go_conv = 1'b1;
                    end
                end else if (is_op || is_eq) begin
                    pop_d     = key_op;
                    ent_act_d = 1'b0;
                    if (!ent_act_q) begin
                        src     = acc_q;
                        go_conv = 1'b1;
                    end else if (pop_q == OP_DIV) begin
                        if (ent_q == '0) begin
                            go_err = 1'b1;
                        end else begin
                            rem_d   = '0;
                            quo_d   = acc_abs;
                            dvs_d   = ent_q;
                            qneg_d  = acc_q[W-1] ^ ent_neg_q;
                            iter_d  = '0;
                            state_d = DIV;
                        end
                    end else if (res_abs > LIM2) begin
                        go_err = 1'b1;
                    end else begin
                        acc_d   = res[W-1:0];
                        src     = res[W-1:0];
                        go_conv = 1'b1;
                    end
                end else if (is_tog) begin
                    if (ent_act_q) begin
                        ent_neg_d = !ent_neg_q;
                        src       = -ent_s;
                    end else begin
                        acc_d = -acc_q;
                        src   = -acc_q;
                    end
                    go_conv = 1'b1;
                end
            end
            DIV: begin
                rem_d  = rem_n;
                quo_d  = quo_n;
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(W - 1)) begin
                    if (quo_n > LIMW) begin
                        go_err = 1'b1;
                    end else begin
                        acc_d   = quo_s;
                        src     = quo_s;
                        go_conv = 1'b1;
                    end
                end
            end
            CONV: begin
                bcd_d  = bcd_n;
                bin_d  = bin_n;
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(W - 1))
                    state_d = DONE;
            end
            DONE: begin
                disp_bcd_d   = err_q ? '0 : bcd_q;
                disp_neg_d   = !err_q && cneg_q;
                err_out_d    = err_q;
                disp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (go_err) begin
            acc_d     = '0;
            ent_d     = '0;
            ent_neg_d = 1'b0;
            ent_act_d = 1'b0;
            cnt_d     = '0;
            pop_d     = OP_NONE;
            err_d     = 1'b1;
            state_d   = DONE;
        end
        // A negative source is never zero, so its sign can drive disp_neg directly.
        if (go_conv) begin
            bin_d   = src[W-1] ? -src : src;
            bcd_d   = '0;
            cneg_d  = src[W-1];
            iter_d  = '0;
            state_d = CONV;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pop_q        <= OP_NONE;
            acc_q        <= '0;
            ent_q        <= '0;
            ent_neg_q    <= 1'b0;
            ent_act_q    <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            iter_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            bin_q        <= '0;
            qneg_q       <= 1'b0;
            cneg_q       <= 1'b0;
            bcd_q        <= '0;
            disp_bcd_q   <= '0;
            disp_neg_q   <= 1'b0;
            err_out_q    <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            acc_q        <= acc_d;
            ent_q        <= ent_d;
            ent_neg_q    <= ent_neg_d;
            ent_act_q    <= ent_act_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            iter_q       <= iter_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            bin_q        <= bin_d;
            qneg_q       <= qneg_d;
            cneg_q       <= cneg_d;
            bcd_q        <= bcd_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_neg_q   <= disp_neg_d;
            err_out_q    <= err_out_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign disp_bcd   = disp_bcd_q;
    assign disp_neg   = disp_neg_q;
    assign err        = err_out_q;
    assign disp_valid = disp_valid_q;
endmodule
